exe_bypass_net: RTL and testbench



---
 rtl/lagarto_bypass_pkg.sv | 33 +++
 rtl/bypass_hist_buf.sv | 76 +++++++
 rtl/exe_bypass_net.sv | 130 +++++++++++++
 tb/tb_exe_bypass_net.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lagarto_bypass_pkg.sv
// lagarto_bypass_pkg
// Shared definitions for the execute-stage bypass network:
//   - x0 address constant (never forwarded)
//   - legal ranges for the structural parameters
//   - popcount helper for the hit counter
// The history entry layout {vld, addr, data} depends on XLEN/RADDR_W,
// which a package cannot take as parameters. Each user therefore declares
// hist_entry_t locally in the field order given by HIST_ENTRY_FIELDS.
package lagarto_bypass_pkg;

  localparam int unsigned X0_ADDR = 0;

  localparam int unsigned NUM_SRC_MIN    = 1;
  localparam int unsigned NUM_SRC_MAX    = 4;
  localparam int unsigned NUM_WB_MIN     = 1;
  localparam int unsigned NUM_WB_MAX     = 4;
  localparam int unsigned HIST_DEPTH_MIN = 1;
  localparam int unsigned HIST_DEPTH_MAX = 4;

  // Documentation of the entry layout: MSB-first {vld, addr, data}.
  localparam int unsigned HIST_ENTRY_FIELDS = 3;

  // Hits are padded to NUM_SRC_MAX bits before counting.
  function automatic logic [2:0] popcnt4(input logic [NUM_SRC_MAX-1:0] v);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < NUM_SRC_MAX; i++) begin
      s = s + {2'b00, v[i]};
    end
    return s;
  endfunction

endpackage

// File: rtl/bypass_hist_buf.sv
// bypass_hist_buf
// HIST_DEPTH x NUM_WB shift history of writebacks. Slot 0 captures the
// current WB ports each cycle, slot k captures slot k-1. Shifting is
// unconditional because register-file writes never stall.
// Ports:
//   CLK, RSTN          clock, async active-low reset (clears every vld)
//   WB_WE/ADDR/DATA    current writeback ports, flattened per port
//   hist_vld/addr/data history flattened as index k*NUM_WB+p (k = slot)
module bypass_hist_buf
  import lagarto_bypass_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned NUM_WB     = 2,
  parameter int unsigned HIST_DEPTH = 2
) (
  input  logic                                  CLK,
  input  logic                                  RSTN,
  input  logic [NUM_WB-1:0]                     WB_WE,
  input  logic [NUM_WB*RADDR_W-1:0]             WB_ADDR,
  input  logic [NUM_WB*XLEN-1:0]                WB_DATA,
  output logic [HIST_DEPTH*NUM_WB-1:0]          hist_vld,
  output logic [HIST_DEPTH*NUM_WB*RADDR_W-1:0]  hist_addr,
  output logic [HIST_DEPTH*NUM_WB*XLEN-1:0]     hist_data
);

  typedef struct packed {
    logic               vld;
    logic [RADDR_W-1:0] addr;
    logic [XLEN-1:0]    data;
  } hist_entry_t;

  hist_entry_t slot_q [HIST_DEPTH][NUM_WB];
  hist_entry_t slot_d [HIST_DEPTH][NUM_WB];

  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      slot_d[0][p].addr = WB_ADDR[p*RADDR_W +: RADDR_W];
      slot_d[0][p].data = WB_DATA[p*XLEN +: XLEN];
      // A write to x0 is stored invalid so x0 can never be forwarded.
      slot_d[0][p].vld  = WB_WE[p] && (WB_ADDR[p*RADDR_W +: RADDR_W] != RADDR_W'(X0_ADDR));
    end
    for (int k = 1; k < HIST_DEPTH; k++) begin
      for (int p = 0; p < NUM_WB; p++) begin
        slot_d[k][p] = slot_q[k-1][p];
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        for (int p = 0; p < NUM_WB; p++) begin
          slot_q[k][p] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < HIST_DEPTH; k++) begin
        for (int p = 0; p < NUM_WB; p++) begin
          slot_q[k][p] <= slot_d[k][p];
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < HIST_DEPTH; k++) begin
      for (int p = 0; p < NUM_WB; p++) begin
        hist_vld[k*NUM_WB+p]                    = slot_q[k][p].vld;
        hist_addr[(k*NUM_WB+p)*RADDR_W +: RADDR_W] = slot_q[k][p].addr;
        hist_data[(k*NUM_WB+p)*XLEN +: XLEN]       = slot_q[k][p].data;
      end
    end
  end

endmodule

// File: rtl/exe_bypass_net.sv
// exe_bypass_net
// Execute-stage operand bypass network. For each of NUM_SRC operands it
// forwards the youngest matching writeback (current WB ports, then history
// slots 0..HIST_DEPTH-1), otherwise passes register-file read data.
// Also keeps a saturating count of forwarded valid operands.
// Ports:
//   CLK, RSTN            clock, async active-low reset
//   SRC_VALID/ADDR       operand use flags and source addresses
//   RR_DATA              register-file read data per operand
//   WB_WE/ADDR/DATA      writeback ports
//   CNT_CLR              synchronous hit-counter clear (beats increment)
//   BYPASS_DATA/HIT      resolved operand and forwarded flag (combinational)
//   HIT_CNT              registered saturating hit count
module exe_bypass_net
  import lagarto_bypass_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned RADDR_W    = 5,
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned NUM_WB     = 2,
  parameter int unsigned HIST_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                      CLK,
  input  logic                      RSTN,
  input  logic [NUM_SRC-1:0]        SRC_VALID,
  input  logic [NUM_SRC*RADDR_W-1:0] SRC_ADDR,
  input  logic [NUM_SRC*XLEN-1:0]   RR_DATA,
  input  logic [NUM_WB-1:0]         WB_WE,
  input  logic [NUM_WB*RADDR_W-1:0] WB_ADDR,
  input  logic [NUM_WB*XLEN-1:0]    WB_DATA,
  input  logic                      CNT_CLR,
  output logic [NUM_SRC*XLEN-1:0]   BYPASS_DATA,
  output logic [NUM_SRC-1:0]        BYPASS_HIT,
  output logic [CNT_W-1:0]          HIT_CNT
);

  logic [HIST_DEPTH*NUM_WB-1:0]         hist_vld;
  logic [HIST_DEPTH*NUM_WB*RADDR_W-1:0] hist_addr;
  logic [HIST_DEPTH*NUM_WB*XLEN-1:0]    hist_data;

  bypass_hist_buf #(
    .XLEN       (XLEN),
    .RADDR_W    (RADDR_W),
    .NUM_WB     (NUM_WB),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .WB_WE     (WB_WE),
    .WB_ADDR   (WB_ADDR),
    .WB_DATA   (WB_DATA),
    .hist_vld  (hist_vld),
    .hist_addr (hist_addr),
    .hist_data (hist_data)
  );

  logic [NUM_SRC-1:0] src_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RADDR_W-1:0] src_addr;
    logic [XLEN-1:0]    src_data;
    logic               hit;

    assign src_addr = SRC_ADDR[i*RADDR_W +: RADDR_W];

    // Scan oldest to youngest, low port to high port; a later match
    // overwrites an earlier one, giving youngest-age / highest-port priority.
    always_comb begin
      src_data = RR_DATA[i*XLEN +: XLEN];
      hit      = 1'b0;
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        for (int p = 0; p < NUM_WB; p++) begin
          if (hist_vld[k*NUM_WB+p] &&
              (hist_addr[(k*NUM_WB+p)*RADDR_W +: RADDR_W] == src_addr)) begin
            hit      = 1'b1;
            src_data = hist_data[(k*NUM_WB+p)*XLEN +: XLEN];
          end
        end
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (WB_WE[p] && (WB_ADDR[p*RADDR_W +: RADDR_W] == src_addr)) begin
          hit      = 1'b1;
          src_data = WB_DATA[p*XLEN +: XLEN];
        end
      end
      // Age-0 writes to x0 are not filtered above; x0 always reads RR_DATA.
      if (src_addr == RADDR_W'(X0_ADDR)) begin
        hit      = 1'b0;
        src_data = RR_DATA[i*XLEN +: XLEN];
      end
    end

    assign BYPASS_DATA[i*XLEN +: XLEN] = src_data;
    assign src_hit[i]                  = hit;
  end

  assign BYPASS_HIT = src_hit;

  logic [NUM_SRC_MAX-1:0] hit_vec;
  logic [2:0]             hit_pop;
  logic [CNT_W:0]         cnt_sum;
  logic [CNT_W-1:0]       hit_cnt_d;
  logic [CNT_W-1:0]       hit_cnt_q;

  always_comb begin
    hit_vec              = '0;
    hit_vec[NUM_SRC-1:0] = src_hit & SRC_VALID;
    hit_pop              = popcnt4(hit_vec);
    cnt_sum              = {1'b0, hit_cnt_q} + (CNT_W+1)'(hit_pop);
    if (CNT_CLR) begin
      hit_cnt_d = '0;
    end else if (cnt_sum[CNT_W]) begin
      hit_cnt_d = '1;
    end else begin
      hit_cnt_d = cnt_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hit_cnt_q <= '0;
    end else begin
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign HIT_CNT = hit_cnt_q;

endmodule

// File: tb/tb_exe_bypass_net.sv
module tb_exe_bypass_net;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int NS   = 2;
  localparam int NW   = 2;
  localparam int HD   = 2;
  localparam int CW   = 4;

  logic              CLK;
  logic              RSTN;
  logic [NS-1:0]     SRC_VALID;
  logic [NS*RW-1:0]  SRC_ADDR;
  logic [NS*XLEN-1:0] RR_DATA;
  logic [NW-1:0]     WB_WE;
  logic [NW*RW-1:0]  WB_ADDR;
  logic [NW*XLEN-1:0] WB_DATA;
  logic              CNT_CLR;
  logic [NS*XLEN-1:0] BYPASS_DATA;
  logic [NS-1:0]     BYPASS_HIT;
  logic [CW-1:0]     HIT_CNT;

  int n_checks = 0;
  int n_errors = 0;

  exe_bypass_net #(
    .XLEN(XLEN), .RADDR_W(RW), .NUM_SRC(NS), .NUM_WB(NW),
    .HIST_DEPTH(HD), .CNT_W(CW)
  ) dut (
    .CLK(CLK), .RSTN(RSTN),
    .SRC_VALID(SRC_VALID), .SRC_ADDR(SRC_ADDR), .RR_DATA(RR_DATA),
    .WB_WE(WB_WE), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .CNT_CLR(CNT_CLR),
    .BYPASS_DATA(BYPASS_DATA), .BYPASS_HIT(BYPASS_HIT), .HIT_CNT(HIT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_wb(input int p, input logic we, input logic [RW-1:0] a, input logic [XLEN-1:0] d);
    WB_WE[p]             = we;
    WB_ADDR[p*RW +: RW]  = a;
    WB_DATA[p*XLEN +: XLEN] = d;
  endtask

  task automatic clr_wb();
    WB_WE   = '0;
    WB_ADDR = '0;
    WB_DATA = '0;
  endtask

  task automatic set_src(input int i, input logic v, input logic [RW-1:0] a, input logic [XLEN-1:0] rr);
    SRC_VALID[i]            = v;
    SRC_ADDR[i*RW +: RW]    = a;
    RR_DATA[i*XLEN +: XLEN] = rr;
  endtask

  function automatic logic [63:0] bd(input int i);
    return BYPASS_DATA[i*XLEN +: XLEN];
  endfunction

  initial begin
    RSTN = 1'b0; CNT_CLR = 1'b0;
    SRC_VALID = '0; SRC_ADDR = '0; RR_DATA = '0;
    clr_wb();
    #12;
    check("rst_cnt", 64'(HIT_CNT), 64'd0);
    step(); step();
    RSTN = 1'b1;
    step();

    // Reset then idle
    set_src(0, 1'b1, 5'd3, 64'hAAAA);
    set_src(1, 1'b0, 5'd0, 64'h0);
    settle();
    check("idle_data", bd(0), 64'hAAAA);
    check("idle_hit", 64'(BYPASS_HIT), 64'd0);
    check("idle_cnt", 64'(HIT_CNT), 64'd0);

    // Age ordering: x5
    set_src(0, 1'b0, 5'd5, 64'hDEAD);
    set_wb(0, 1'b1, 5'd5, 64'h11);
    settle();
    check("age0_t", bd(0), 64'h11);
    check("age0_t_hit", 64'(BYPASS_HIT[0]), 64'd1);
    step();
    clr_wb();
    set_wb(1, 1'b1, 5'd5, 64'h22);
    settle();
    check("age_t1", bd(0), 64'h22);
    step();
    clr_wb();
    settle();
    check("age_t2_slot0", bd(0), 64'h22);
    step();
    settle();
    check("age_t3_slot1", bd(0), 64'h22);
    check("age_t3_hit", 64'(BYPASS_HIT[0]), 64'd1);
    step();
    settle();
    check("age_t4_rr", bd(0), 64'hDEAD);
    check("age_t4_hit", 64'(BYPASS_HIT[0]), 64'd0);

    // Same-cycle port conflict on x7
    set_src(0, 1'b0, 5'd7, 64'h700);
    set_wb(0, 1'b1, 5'd7, 64'h1);
    set_wb(1, 1'b1, 5'd7, 64'h2);
    settle();
    check("conf_age0", bd(0), 64'h2);
    step();
    clr_wb();
    settle();
    check("conf_age1", bd(0), 64'h2);
    step();
    settle();
    check("conf_age2", bd(0), 64'h2);
    step();
    settle();
    check("conf_age3_rr", bd(0), 64'h700);

    // x0 never forwarded
    set_src(0, 1'b0, 5'd0, 64'h55);
    set_src(1, 1'b0, 5'd0, 64'h66);
    set_wb(0, 1'b1, 5'd0, 64'hFF);
    settle();
    check("x0_age0_d", bd(0), 64'h55);
    check("x0_age0_h", 64'(BYPASS_HIT), 64'd0);
    step();
    clr_wb();
    settle();
    check("x0_age1_d", bd(1), 64'h66);
    check("x0_age1_h", 64'(BYPASS_HIT), 64'd0);
    step();
    settle();
    check("x0_age2_d", bd(0), 64'h55);
    check("x0_age2_h", 64'(BYPASS_HIT), 64'd0);

    // Multi-source: clear counter, x9 written two cycles before x4
    CNT_CLR = 1'b1;
    set_wb(1, 1'b1, 5'd9, 64'h99);
    step();
    CNT_CLR = 1'b0;
    clr_wb();
    settle();
    check("clr_cnt", 64'(HIT_CNT), 64'd0);
    step();
    set_wb(0, 1'b1, 5'd4, 64'h44);
    set_src(0, 1'b1, 5'd4, 64'h400);
    set_src(1, 1'b1, 5'd9, 64'h900);
    settle();
    check("ms_d0", bd(0), 64'h44);
    check("ms_d1", bd(1), 64'h99);
    check("ms_hit", 64'(BYPASS_HIT), 64'd3);
    step();
    clr_wb();
    SRC_VALID = '0;
    settle();
    check("ms_cnt2", 64'(HIT_CNT), 64'd2);
    // x4 now at age 1; both operands read x4, only src0 valid
    set_src(0, 1'b1, 5'd4, 64'h400);
    set_src(1, 1'b0, 5'd4, 64'h401);
    settle();
    check("ms_hit_both", 64'(BYPASS_HIT), 64'd3);
    step();
    SRC_VALID = '0;
    settle();
    check("ms_cnt3", 64'(HIT_CNT), 64'd3);

    // Saturation: 11 more single hits -> 14
    set_wb(0, 1'b1, 5'd10, 64'hA0);
    set_src(0, 1'b1, 5'd10, 64'h0);
    set_src(1, 1'b0, 5'd10, 64'h0);
    for (int n = 0; n < 11; n++) step();
    settle();
    check("sat_pre14", 64'(HIT_CNT), 64'd14);
    SRC_VALID = 2'b11;
    step();
    settle();
    check("sat_15", 64'(HIT_CNT), 64'd15);
    step();
    settle();
    check("sat_hold", 64'(HIT_CNT), 64'd15);
    CNT_CLR = 1'b1;
    step();
    CNT_CLR = 1'b0;
    SRC_VALID = '0;
    clr_wb();
    settle();
    check("clr_prio", 64'(HIT_CNT), 64'd0);

    // Async reset mid-cycle
    set_wb(0, 1'b1, 5'd6, 64'h66);
    set_src(0, 1'b1, 5'd6, 64'h600);
    step();
    clr_wb();
    SRC_VALID = '0;
    settle();
    check("ar_pre_d", bd(0), 64'h66);
    check("ar_pre_cnt", 64'(HIT_CNT), 64'd1);
    #1;
    RSTN = 1'b0;
    #1;
    check("ar_d", bd(0), 64'h600);
    check("ar_hit", 64'(BYPASS_HIT[0]), 64'd0);
    check("ar_cnt", 64'(HIT_CNT), 64'd0);
    set_wb(1, 1'b1, 5'd6, 64'h77);
    #1;
    check("ar_age0_d", bd(0), 64'h77);
    check("ar_age0_h", 64'(BYPASS_HIT[0]), 64'd1);
    step();
    RSTN = 1'b1;
    clr_wb();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
